// File: rtl/response_bus_arbiter_if.sv
// Response bus arbitration signals shared between the slave units and the
// response bus arbiter.
//   response_breq  : per-slave bus request               (slave -> arbiter)
//   response_bhold : per-slave request to keep the grant (slave -> arbiter)
//   response_bgnt  : registered one-hot grant            (arbiter -> slaves)
//   bus_busy       : OR of response_bgnt, registered     (arbiter -> slaves)
//   owner          : index of current grantee            (arbiter -> slaves)
//   hold_timeout   : tenure forcibly ended at MAX_HOLD   (arbiter -> slaves)
// Modport master is the arbiter side, modport slave the requester side.
interface response_bus_arbiter_if #(
  parameter int NUM_SLAVES = 4,
  parameter int IDX_WIDTH  = $clog2(NUM_SLAVES)
);
  logic [NUM_SLAVES-1:0] response_breq;
  logic [NUM_SLAVES-1:0] response_bhold;
  logic [NUM_SLAVES-1:0] response_bgnt;
  logic                  bus_busy;
  logic [IDX_WIDTH-1:0]  owner;
  logic                  hold_timeout;

  modport master (
    input  response_breq,
    input  response_bhold,
    output response_bgnt,
    output bus_busy,
    output owner,
    output hold_timeout
  );

  modport slave (
    output response_breq,
    output response_bhold,
    input  response_bgnt,
    input  bus_busy,
    input  owner,
    input  hold_timeout
  );
endinterface

// File: rtl/response_bus_arbiter.sv
// Round-robin arbiter for the shared response bus.
// Each slave raises response_breq to ask for the bus and response_bhold to
// keep it for another cycle. Grants are registered and one-hot; a tenure is
// capped at MAX_HOLD cycles, after which the bus is handed on and
// hold_timeout pulses for one cycle.
// Ports:
//   clock : system clock
//   reset : synchronous, active-high reset
//   bus   : arbitration signals (master modport), see response_bus_arbiter_if
module response_bus_arbiter #(
  parameter int NUM_SLAVES = 4,
  parameter int MAX_HOLD   = 8,
  parameter int IDX_WIDTH  = $clog2(NUM_SLAVES)
) (
  input  logic                          clock,
  input  logic                          reset,
  response_bus_arbiter_if.master        bus
);

  localparam int CNT_WIDTH = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state_q, state_n;
  logic [CNT_WIDTH-1:0]  hold_cnt_q, hold_cnt_n;
  logic [IDX_WIDTH-1:0]  rr_ptr_q, rr_ptr_n;
  logic [IDX_WIDTH-1:0]  owner_q, owner_n;
  logic [NUM_SLAVES-1:0] bgnt_q, bgnt_n;
  logic                  timeout_q, timeout_n;

  logic [IDX_WIDTH-1:0]  owner_inc;
  logic [IDX_WIDTH-1:0]  arb_base;
  logic [IDX_WIDTH-1:0]  win;
  logic                  win_found;
  logic                  owner_hold;

  assign owner_inc  = (owner_q == IDX_WIDTH'(NUM_SLAVES - 1)) ? '0
                                                               : owner_q + IDX_WIDTH'(1);
  assign owner_hold = bus.response_bhold[owner_q];

  // On release the pointer moves past the owner before arbitrating, so the
  // scan in GRANT starts at owner+1 rather than the stored rr_ptr.
  assign arb_base = (state_q == GRANT) ? owner_inc : rr_ptr_q;

  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!win_found &&
          bus.response_breq[IDX_WIDTH'((32'(arb_base) + i) % NUM_SLAVES)]) begin
        win_found = 1'b1;
        win       = IDX_WIDTH'((32'(arb_base) + i) % NUM_SLAVES);
      end
    end
  end

  always_comb begin
    state_n    = state_q;
    hold_cnt_n = hold_cnt_q;
    rr_ptr_n   = rr_ptr_q;
    owner_n    = owner_q;
    bgnt_n     = bgnt_q;
    timeout_n  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_n    = GRANT;
          owner_n    = win;
          bgnt_n     = NUM_SLAVES'(1) << win;
          hold_cnt_n = CNT_WIDTH'(1);
        end else begin
          bgnt_n     = '0;
          hold_cnt_n = '0;
        end
      end

      GRANT: begin
        if (owner_hold && (hold_cnt_q < CNT_WIDTH'(MAX_HOLD))) begin
          hold_cnt_n = hold_cnt_q + CNT_WIDTH'(1);
        end else begin
          // Voluntary or forced release; hand over in the same cycle.
          rr_ptr_n  = owner_inc;
          timeout_n = owner_hold;
          if (win_found) begin
            owner_n    = win;
            bgnt_n     = NUM_SLAVES'(1) << win;
            hold_cnt_n = CNT_WIDTH'(1);
          end else begin
            state_n    = IDLE;
            bgnt_n     = '0;
            hold_cnt_n = '0;
          end
        end
      end

      default: begin
        state_n    = IDLE;
        bgnt_n     = '0;
        hold_cnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      bgnt_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_n;
      hold_cnt_q <= hold_cnt_n;
      rr_ptr_q   <= rr_ptr_n;
      owner_q    <= owner_n;
      bgnt_q     <= bgnt_n;
      timeout_q  <= timeout_n;
    end
  end

  assign bus.response_bgnt = bgnt_q;
  assign bus.bus_busy      = (state_q == GRANT);
  assign bus.owner         = owner_q;
  assign bus.hold_timeout  = timeout_q;

  grant_onehot: assert property (@(posedge clock) $onehot0(bgnt_q));
  busy_matches_grant: assert property (@(posedge clock) (|bgnt_q) == (state_q == GRANT));

endmodule

// File: tb/tb_response_bus_arbiter.sv
module tb_response_bus_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  response_bus_arbiter_if #(.NUM_SLAVES(4)) bus0 ();
  response_bus_arbiter_if #(.NUM_SLAVES(4)) bus1 ();

  response_bus_arbiter #(.NUM_SLAVES(4), .MAX_HOLD(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  response_bus_arbiter #(.NUM_SLAVES(4), .MAX_HOLD(1)) dut_h1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  typedef struct {
    logic       rst;
    logic [3:0] breq;
    logic [3:0] bhold;
    logic [3:0] exp_bgnt;
    logic [1:0] exp_owner;
    logic       chk_owner;
    logic       exp_to;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(logic r, logic [3:0] breq, logic [3:0] bhold);
    reset = r;
    bus0.response_breq  = breq;
    bus0.response_bhold = bhold;
    bus1.response_breq  = breq;
    bus1.response_bhold = bhold;
    @(posedge clock);
    #1;
  endtask

  task automatic check_dut(int which, string tag, logic [3:0] bgnt, logic [1:0] own,
                           logic chk_own, logic to);
    logic [3:0] a_bgnt;
    logic       a_busy;
    logic [1:0] a_own;
    logic       a_to;
    if (which == 0) begin
      a_bgnt = bus0.response_bgnt; a_busy = bus0.bus_busy;
      a_own  = bus0.owner;         a_to   = bus0.hold_timeout;
    end else begin
      a_bgnt = bus1.response_bgnt; a_busy = bus1.bus_busy;
      a_own  = bus1.owner;         a_to   = bus1.hold_timeout;
    end
    cmp({tag, " bgnt"}, 32'(a_bgnt), 32'(bgnt));
    cmp({tag, " busy"}, 32'(a_busy), 32'(bgnt != 4'b0000));
    if (chk_own) cmp({tag, " owner"}, 32'(a_own), 32'(own));
    cmp({tag, " timeout"}, 32'(a_to), 32'(to));
  endtask

  vec_t vecs[$];

  initial begin
    // Round-robin over all four, single 1-cycle tenure, back-to-back handover,
    // reset mid-tenure. Comments give the rr_ptr value entering each row.
    vecs.push_back('{0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0}); // rr0
    vecs.push_back('{0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1, 0});
    vecs.push_back('{0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1, 0});
    vecs.push_back('{0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1, 0});
    vecs.push_back('{0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0}); // wrap
    vecs.push_back('{0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0}); // rr1, idle
    vecs.push_back('{0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0});
    vecs.push_back('{0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0}); // rr3
    vecs.push_back('{0, 4'b1001, 4'b0000, 4'b1000, 2'd3, 1, 0}); // 3 beats 0 from rr3
    vecs.push_back('{0, 4'b0001, 4'b1000, 4'b1000, 2'd3, 1, 0});
    vecs.push_back('{0, 4'b0001, 4'b1000, 4'b1000, 2'd3, 1, 0});
    vecs.push_back('{0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0}); // no gap
    vecs.push_back('{0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0}); // rr1
    vecs.push_back('{0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 0}); // cycle 1
    vecs.push_back('{0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 0});
    vecs.push_back('{0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 0});
    vecs.push_back('{0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 0}); // cycle 4
    vecs.push_back('{1, 4'b0100, 4'b0100, 4'b0000, 2'd0, 1, 0}); // reset
    vecs.push_back('{0, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1, 0}); // rr0 -> 0
    vecs.push_back('{0, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1, 0}); // rr1 -> 2
    vecs.push_back('{0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0}); // rr3

    // Reset for two cycles, then idle for ten.
    step(1, 4'b0000, 4'b0000);
    check_dut(0, "reset0", 4'b0000, 2'd0, 1, 0);
    step(1, 4'b0000, 4'b0000);
    check_dut(0, "reset1", 4'b0000, 2'd0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 4'b0000, 4'b0000);
      check_dut(0, $sformatf("idle%0d", i), 4'b0000, 2'd0, 1, 0);
    end

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].breq, vecs[i].bhold);
      check_dut(0, $sformatf("vec%0d", i), vecs[i].exp_bgnt, vecs[i].exp_owner,
                vecs[i].chk_owner, vecs[i].exp_to);
    end

    // Hold to MAX_HOLD: slave 1 drops its own breq but keeps bhold; slave 0
    // waits. Slave 1 is granted from rr3 (scan 3,0,1).
    step(0, 4'b0010, 4'b0010);
    check_dut(0, "hold1", 4'b0010, 2'd1, 1, 0);
    for (int i = 2; i <= 8; i++) begin
      step(0, 4'b0001, 4'b0010);
      check_dut(0, $sformatf("hold%0d", i), 4'b0010, 2'd1, 1, 0);
    end
    step(0, 4'b0001, 4'b0010);
    check_dut(0, "timeout", 4'b0001, 2'd0, 1, 1);
    // Non-owner bhold ignored; previous owner wins as sole requester.
    step(0, 4'b0001, 4'b0010);
    check_dut(0, "after_to", 4'b0001, 2'd0, 1, 0);
    step(0, 4'b0000, 4'b0000);
    check_dut(0, "hold_idle", 4'b0000, 2'd0, 0, 0);

    // MAX_HOLD=1 instance: every tenure is one cycle, timeout on every bhold.
    step(1, 4'b0000, 4'b0000);
    check_dut(1, "h1_reset", 4'b0000, 2'd0, 1, 0);
    step(0, 4'b0010, 4'b0010);
    check_dut(1, "h1_g1", 4'b0010, 2'd1, 1, 0);
    step(0, 4'b0010, 4'b0010);
    check_dut(1, "h1_regrant", 4'b0010, 2'd1, 1, 1);
    step(0, 4'b1010, 4'b0010);
    check_dut(1, "h1_handover", 4'b1000, 2'd3, 1, 1);
    step(0, 4'b0000, 4'b1000);
    check_dut(1, "h1_to_idle", 4'b0000, 2'd0, 0, 1);
    step(0, 4'b0000, 4'b0000);
    check_dut(1, "h1_idle", 4'b0000, 2'd0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/response_bus_arbiter.md
Name: response_bus_arbiter

Overview:
- Shares the response bus between NUM_SLAVES slave units (memory, UART, LEDs, ...).
- Each slave requests with response_breq and extends its tenure with response_bhold.
- The arbiter returns a registered one-hot response_bgnt using round-robin priority, with a hold-length limit so no slave can starve the others.
- Sits beside the request/response bus interconnect; a slave's grant enables its response_oe drive.

Parameters:
- NUM_SLAVES, 4, number of requesting slaves (2..16).
- MAX_HOLD, 8, maximum consecutive grant cycles in one tenure (>=1).
- IDX_WIDTH, $clog2(NUM_SLAVES), width of owner index.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- response_breq  input  NUM_SLAVES  per-slave bus request.
- response_bhold  input  NUM_SLAVES  per-slave request to keep the grant next cycle.
- response_bgnt  output  NUM_SLAVES  registered one-hot grant; all-zero when the bus is idle.
- bus_busy  output  1  OR of response_bgnt (registered).
- owner  output  IDX_WIDTH  index of the current grantee; valid only when bus_busy=1.
- hold_timeout  output  1  one-cycle pulse when a tenure is forcibly ended at MAX_HOLD.

Behaviour:
- Clock and reset: one clock, clock; reset is synchronous and active-high.
- Reset values:
  - response_bgnt=0, bus_busy=0, owner=0, hold_timeout=0.
  - State=IDLE, hold_cnt=0, rr_ptr=0 (slave 0 has highest priority).
- States: IDLE, GRANT.
- IDLE:
  - If any response_breq is high at edge t, the winner is the first set bit scanning upward (with wrap) from rr_ptr.
  - response_bgnt[winner]=1 from cycle t+1; owner=winner; hold_cnt=1; go to GRANT.
  - If no request, stay in IDLE with grants 0.
- GRANT (owner holds the bus this cycle):
  - Continue: response_bhold[owner]=1 and hold_cnt<MAX_HOLD. Grant unchanged next cycle; hold_cnt++.
  - Release: response_bhold[owner]=0. Set rr_ptr=owner+1 (mod NUM_SLAVES), then re-arbitrate in the same cycle over the current response_breq using the new rr_ptr. If there is a winner, grant it next cycle with no dead cycle (back-to-back handover, hold_cnt=1). Otherwise go to IDLE.
  - Forced release: response_bhold[owner]=1 and hold_cnt==MAX_HOLD. Same as release, plus hold_timeout=1 for exactly the next cycle.
  - Because of the rr_ptr update, the previous owner has lowest priority in that re-arbitration; it may win only if it is the sole requester.
- Signals the arbiter ignores:
  - response_bhold from non-owners.
  - response_breq from the owner while it holds.
- Minimum tenure is 1 cycle. Maximum tenure is MAX_HOLD cycles.
- Grant latency from request is 1 cycle when the bus is idle.
- Owner drops response_breq mid-tenure: the arbiter ignores it; bhold alone decides continuation.
- Owner index out of range: impossible by construction; response_bgnt must always be zero-hot or one-hot (assertion).
- Reset mid-tenure: the grant is removed on the next edge and all state returns to reset values; a slave's in-flight response is abandoned.
- Simultaneous requests in IDLE: pure rr_ptr order. rr_ptr wraps from NUM_SLAVES-1 to 0.
- MAX_HOLD=1: every tenure is a single cycle, and hold_timeout pulses whenever bhold is high.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, all breq=0 → bgnt=0000, bus_busy=0, owner=0, hold_timeout=0 for 10 cycles.
- Single request, 1-cycle tenure: breq=0100 for 1 cycle at t, bhold=0 → bgnt=0100 at t+1 only, owner=2; bgnt=0000 at t+2.
- Round-robin fairness: breq=1111 held, bhold=0 → grants cycle 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with no idle cycles between them.
- Hold and timeout (MAX_HOLD=8):
  - Slave 1 granted with bhold[1]=1 continuously, breq=0001 also pending → bgnt=0010 for exactly 8 cycles.
  - Then hold_timeout=1 for 1 cycle while bgnt=0001.
- Back-to-back handover:
  - Slave 3 holds 3 cycles (bhold high 2 cycles), slave 0 requesting → bgnt=1000 for 3 cycles, then 0001 the next cycle with no gap.
- Reset mid-tenure: slave 2 in cycle 4 of a hold, reset=1 for 1 cycle → next cycle bgnt=0000 and rr_ptr=0. A subsequent breq=0101 grants slave 0 first.
